// File: rtl/poly_disp_pkg.sv
// Shared polyphony display bus layout and scan FSM states, used by the
// voice packers and the poly_scan reader.
package poly_disp_pkg;
  localparam int SLOTS     = 16;
  localparam int SLOT_W    = 16;
  localparam int BUS_W     = SLOTS * SLOT_W;
  localparam int CNT_W     = 4;
  localparam int NOTE_BASE = 36;
  localparam int NOTE_LSB  = 0;
  localparam int NOTE_W    = 7;
  localparam int ON_BIT    = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } scan_state_e;
endpackage

// File: rtl/poly_slot_dec.sv
// Combinational decode of one display slot into note-on and the restored
// MIDI note (stored offset plus NOTE_BASE, wrapping at 7 bits).
module poly_slot_dec
  import poly_disp_pkg::*;
(
  input  logic [SLOT_W-1:0] slot,
  output logic              on,
  output logic [NOTE_W-1:0] note
);
  logic unused_bits;

  assign on   = slot[ON_BIT];
  assign note = slot[NOTE_LSB +: NOTE_W] + NOTE_W'(NOTE_BASE);

  // Spare slot bits are reserved by the packers.
  assign unused_bits = ^{slot[SLOT_W-1:ON_BIT+1], slot[ON_BIT-1:NOTE_W]};
endmodule

// File: rtl/poly_scan.sv
// Snapshots the 256-bit polyphony display bus on start and walks its 16 slots,
// emitting one note event per slot on a valid/ready stream.
// Define POLY_SCAN_DELTA_EN to emit only slots that changed since the last scan.
module poly_scan
  import poly_disp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BUS_W-1:0]  pd_in,
  output logic              busy,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CNT_W-1:0]  evt_slot,
  output logic [2:0]        evt_voice,
  output logic              evt_ch,
  output logic [NOTE_W-1:0] evt_note,
  output logic              evt_on,
  output logic              done
);
  scan_state_e                   state;
  logic [SLOTS-1:0][SLOT_W-1:0]  snap;
  logic [CNT_W-1:0]              cnt;
  logic [SLOT_W-1:0]             cur_slot;
  logic                          dec_on;
  logic [NOTE_W-1:0]             dec_note;
  logic                          emit_slot;
  logic                          last_slot;

  assign cur_slot  = snap[cnt];
  assign last_slot = (cnt == CNT_W'(SLOTS-1));

  poly_slot_dec u_dec (
    .slot (cur_slot),
    .on   (dec_on),
    .note (dec_note)
  );

`ifdef POLY_SCAN_DELTA_EN
  logic [SLOTS-1:0][NOTE_W:0] hist;
  assign emit_slot = ({dec_on, cur_slot[NOTE_LSB +: NOTE_W]} != hist[cnt]);
`else
  assign emit_slot = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      snap      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      evt_valid <= 1'b0;
      evt_slot  <= '0;
      evt_voice <= '0;
      evt_ch    <= 1'b0;
      evt_note  <= '0;
      evt_on    <= 1'b0;
      done      <= 1'b0;
`ifdef POLY_SCAN_DELTA_EN
      hist      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap  <= pd_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          evt_slot  <= cnt;
          evt_voice <= cnt[CNT_W-1:1];
          evt_ch    <= cnt[0];
          evt_note  <= dec_note;
          evt_on    <= dec_on;
`ifdef POLY_SCAN_DELTA_EN
          hist[cnt] <= {dec_on, cur_slot[NOTE_LSB +: NOTE_W]};
`endif
          if (emit_slot) begin
            evt_valid <= 1'b1;
            state     <= ST_EMIT;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= last_slot ? ST_DONE : ST_LOAD;
          end
        end
        ST_EMIT: begin
          // evt_* stay frozen here until the consumer takes the event.
          if (evt_ready) begin
            evt_valid <= 1'b0;
            cnt       <= cnt + 1'b1;
            state     <= last_slot ? ST_DONE : ST_LOAD;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_scan.sv
// Scoreboard bench for poly_scan: directed scans push expected events, a
// negedge monitor pops and compares on each handshake.
module tb_poly_scan;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [255:0] pd_in = '0;
  logic         evt_ready = 1'b1;
  logic         busy, evt_valid, evt_ch, evt_on, done;
  logic [3:0]   evt_slot;
  logic [2:0]   evt_voice;
  logic [6:0]   evt_note;

  typedef struct {int slot; int note; int on;} exp_t;
  exp_t q[$];
  exp_t m_e;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int rc;
  bit have_prev = 1'b0;
  int h_slot, h_note, h_on;

  poly_scan dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pd_in     (pd_in),
    .busy      (busy),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_slot  (evt_slot),
    .evt_voice (evt_voice),
    .evt_ch    (evt_ch),
    .evt_note  (evt_note),
    .evt_on    (evt_on),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endfunction

  function automatic void push(int s, int n, int o);
    exp_t e;
    e.slot = s; e.note = n; e.on = o;
    q.push_back(e);
  endfunction

  function automatic void set_slot(int k, logic [15:0] v);
    pd_in[16*k +: 16] = v;
  endfunction

  // Monitor: stability during stalls, and scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (reset) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        chk("stall_valid_held", evt_valid, 1);
        chk("stall_slot_held", evt_slot, h_slot);
        chk("stall_note_held", evt_note, h_note);
        chk("stall_on_held", evt_on, h_on);
      end
      if (evt_valid && evt_ready) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_event: got slot %0d, expected no event", evt_slot);
        end else begin
          m_e = q.pop_front();
          chk("evt_slot", evt_slot, m_e.slot);
          chk("evt_voice", evt_voice, m_e.slot >> 1);
          chk("evt_ch", evt_ch, m_e.slot & 1);
          chk("evt_note", evt_note, m_e.note);
          chk("evt_on", evt_on, m_e.on);
        end
        have_prev = 1'b0;
      end else if (evt_valid) begin
        have_prev = 1'b1;
        h_slot = evt_slot; h_note = evt_note; h_on = evt_on;
      end else begin
        have_prev = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  // exp_edge: edge (counted from the start edge) where done is sampled high.
  task automatic run_scan(input int exp_edge, input int exp_first, input int stall_slot,
                          input bit poke);
    int cyc, first_v, stall_left;
    bit stalled;
    cyc = 0; first_v = 0; stall_left = 0; stalled = 1'b0;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (evt_valid && first_v == 0) first_v = cyc + 1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) evt_ready = 1'b1;
      end else if (!stalled && evt_valid && evt_slot == stall_slot) begin
        evt_ready = 1'b0;
        stall_left = 5;
        stalled = 1'b1;
      end
      if (poke) begin
        if (cyc == 1) pd_in = '1;
        if (cyc == 3) start = 1'b1;
        if (cyc == 7) start = 1'b0;
        if (cyc == exp_edge - 2) start = 1'b1;
      end
    end
    start = 1'b0;
    chk("done_seen", done, 1);
    chk("done_edge", cyc + 1, exp_edge);
    chk("busy_at_done", busy, 0);
    if (exp_first > 0) chk("first_valid_edge", first_v, exp_first);
    repeat (3) begin @(posedge clk); #1; end
    chk("done_pulses", done_cnt, 1);
    chk("done_low_after", done, 0);
    chk("busy_idle", busy, 0);
    chk("queue_drained", q.size(), 0);
    q.delete();
    evt_ready = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_slot", evt_slot, 0);
    chk("rst_note", evt_note, 0);
    chk("rst_on", evt_on, 0);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef POLY_SCAN_DELTA_EN
    pd_in = '0;
    set_slot(5, 16'h0200);
    push(5, 36, 1);
    run_scan(19, 0, -1, 1'b0);
    push(5, 36, 1);
    q.delete();
    run_scan(18, 0, -1, 1'b0);
    set_slot(5, 16'h0000);
    push(5, 36, 0);
    run_scan(19, 0, -1, 1'b0);
`else
    // Basic scan, ready tied high.
    pd_in = '0;
    set_slot(0, 16'h0207);
    set_slot(1, 16'h0010);
    push(0, 43, 1);
    push(1, 52, 0);
    for (int k = 2; k < 16; k++) push(k, 36, 0);
    run_scan(34, 2, -1, 1'b0);

    // Wrap, ignored bits, and a 5-cycle stall on slot 3.
    pd_in = '0;
    set_slot(2, 16'hFC64);
    set_slot(3, 16'hFE64);
    set_slot(4, 16'h0180);
    set_slot(15, 16'h027F);
    push(0, 36, 0); push(1, 36, 0);
    push(2, 8, 0);  push(3, 8, 1);  push(4, 36, 0);
    for (int k = 5; k < 15; k++) push(k, 36, 0);
    push(15, 35, 1);
    run_scan(39, 2, 3, 1'b0);

    // start while busy and in the DONE cycle, pd_in changed after snapshot.
    pd_in = '0;
    for (int k = 0; k < 16; k++) begin
      set_slot(k, 16'h0200 | 16'(k));
      push(k, 36 + k, 1);
    end
    run_scan(34, 2, -1, 1'b1);

    // Reset while slot 7 is stalled in EMIT.
    pd_in = '0;
    for (int k = 0; k < 16; k++) set_slot(k, 16'h0200 | 16'(k));
    for (int k = 0; k < 7; k++) push(k, 36 + k, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rc = 0;
    while (!(evt_valid && evt_slot == 4'd7) && rc < 100) begin
      @(posedge clk); #1;
      rc++;
    end
    evt_ready = 1'b0;
    chk("reach_slot7", evt_slot, 7);
    repeat (2) begin @(posedge clk); #1; end
    chk("slot7_still_valid", evt_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_slot", evt_slot, 0);
    chk("mid_rst_note", evt_note, 0);
    chk("mid_rst_done", done, 0);
    reset = 1'b0;
    evt_ready = 1'b1;
    chk("pre_rst_events", q.size(), 0);
    q.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) push(k, 36 + k, 1);
    run_scan(34, 2, -1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
